// File: rtl/control_types.sv
// control_types: shared memory-op and load/store FSM types plus lane helpers
package control_types;
  typedef enum logic [2:0] {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW} mem_op_t;
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} mau_state_t;
  // 0 = byte, 1 = halfword, 2 = word
  function automatic logic [1:0] op_size(mem_op_t op);
    return (op == MEM_LB || op == MEM_LBU || op == MEM_SB) ? 2'd0 :
           (op == MEM_LH || op == MEM_LHU || op == MEM_SH) ? 2'd1 : 2'd2;
  endfunction
  function automatic logic misaligned(mem_op_t op, logic [1:0] off);
    return (op_size(op) == 2'd1 && off[0]) || (op_size(op) == 2'd2 && off != 2'd0);
  endfunction
  function automatic logic [3:0] lane_be(mem_op_t op, logic [1:0] off);
    return op_size(op) == 2'd0 ? 4'b0001 << off :
           op_size(op) == 2'd1 ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
  endfunction
  function automatic logic [31:0] lane_wdata(mem_op_t op, logic [31:0] d);
    return op_size(op) == 2'd0 ? {4{d[7:0]}} : op_size(op) == 2'd1 ? {2{d[15:0]}} : d;
  endfunction
endpackage

// File: rtl/mem_access_unit_load_align.sv
// mem_load_align: lane extraction and sign/zero extension of a read word
module mem_load_align
  import control_types::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      byte_off,
  input  mem_op_t         mem_op,
  output logic [XLEN-1:0] data
);
  logic [XLEN-1:0] sh;
  always_comb begin
    sh = rdata >> {byte_off, 3'b000};
    data = mem_op == MEM_LB  ? {{(XLEN-8){sh[7]}}, sh[7:0]} :
           mem_op == MEM_LBU ? {{(XLEN-8){1'b0}}, sh[7:0]} :
           mem_op == MEM_LH  ? {{(XLEN-16){sh[15]}}, sh[15:0]} :
           mem_op == MEM_LHU ? {{(XLEN-16){1'b0}}, sh[15:0]} : sh;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit driving a req/gnt/rvalid data bus
module mem_access_unit
  import control_types::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_do_read_ctrl,
  input  logic            mem_do_write_ctrl,
  input  mem_op_t         mem_op,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned_fault,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata
);
  mau_state_t state, state_nxt;
  logic access, mis, go, r_we;
  logic [1:0] r_off;
  mem_op_t r_op;
  logic [XLEN-1:0] ext;
  mem_load_align #(.XLEN(XLEN)) u_align (
    .rdata(dmem_rdata),
    .byte_off(r_off),
    .mem_op(r_op),
    .data(ext)
  );
  always_comb begin
    access = mem_do_read_ctrl | mem_do_write_ctrl;
    mis = misaligned(mem_op, addr[1:0]);
    go = state == IDLE && access && !mis;
    misaligned_fault = state == IDLE && access && mis;
    stall = go || state == REQ || state == RESP;
    state_nxt = go ? REQ :
                state == REQ && dmem_gnt ? (r_we ? DONE : RESP) :
                state == RESP && dmem_rvalid ? DONE :
                state == DONE ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      r_we <= 1'b0;
      r_off <= 2'd0;
      r_op <= MEM_LB;
      dmem_addr <= '0;
      dmem_be <= 4'd0;
      dmem_wdata <= '0;
      load_data <= '0;
    end else begin
      state <= state_nxt;
      if (go) begin
        r_we <= mem_do_write_ctrl;
        r_off <= addr[1:0];
        r_op <= mem_op;
        dmem_addr <= {addr[XLEN-1:2], 2'b00};
        dmem_be <= lane_be(mem_op, addr[1:0]);
        dmem_wdata <= lane_wdata(mem_op, wdata);
      end
      if (state == RESP && dmem_rvalid) load_data <= ext;
    end
  end
  assign dmem_req = state == REQ;
  assign dmem_we = dmem_req & r_we;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized bus-timing bench against a transaction-level model
module tb_mem_access_unit;
  import control_types::*;
  logic clk = 0, rst = 1;
  logic rd_ctrl = 0, wr_ctrl = 0, gnt = 0, rvalid = 0;
  mem_op_t op = MEM_LB;
  logic [31:0] addr = 0, wdata = 0, rdata = 0;
  logic stall, fault, req, we;
  logic [31:0] load_data, daddr, dwdata;
  logic [3:0] be;
  int checks = 0, errors = 0, stall_cnt = 0;
  logic e_stall = 0, e_fault = 0, e_req = 0, e_we = 0;
  logic [31:0] e_addr = 0, e_wd = 0, e_load = 0;
  logic [3:0] e_be = 0;

  mem_access_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .mem_do_read_ctrl(rd_ctrl), .mem_do_write_ctrl(wr_ctrl),
    .mem_op(op), .addr(addr), .wdata(wdata),
    .stall(stall), .load_data(load_data), .misaligned_fault(fault),
    .dmem_req(req), .dmem_we(we), .dmem_addr(daddr), .dmem_be(be),
    .dmem_wdata(dwdata), .dmem_gnt(gnt), .dmem_rvalid(rvalid), .dmem_rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic check(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic int sz(mem_op_t o);
    return (o == MEM_LB || o == MEM_LBU || o == MEM_SB) ? 1 :
           (o == MEM_LH || o == MEM_LHU || o == MEM_SH) ? 2 : 4;
  endfunction
  function automatic bit is_load(mem_op_t o);
    return o == MEM_LB || o == MEM_LH || o == MEM_LW || o == MEM_LBU || o == MEM_LHU;
  endfunction
  function automatic bit m_mis(mem_op_t o, logic [31:0] a);
    return (a % sz(o)) != 0;
  endfunction
  function automatic logic [3:0] m_be(mem_op_t o, logic [31:0] a);
    int s = sz(o);
    return s == 4 ? 4'hF : 4'(((1 << s) - 1) << (a % 4));
  endfunction
  function automatic logic [31:0] m_wd(mem_op_t o, logic [31:0] d);
    int s = sz(o);
    return s == 1 ? (d & 32'hFF) * 32'h01010101 : s == 2 ? (d & 32'hFFFF) * 32'h00010001 : d;
  endfunction
  function automatic logic [31:0] m_ld(mem_op_t o, logic [31:0] rd, logic [31:0] a);
    logic [31:0] v = rd >> (8 * (a % 4));
    int b;
    if (sz(o) == 4) return v;
    b = sz(o) == 1 ? int'(v & 32'hFF) : int'(v & 32'hFFFF);
    if (o == MEM_LB && b >= 128) b -= 256;
    if (o == MEM_LH && b >= 32768) b -= 65536;
    return 32'(b);
  endfunction

  always @(negedge clk) begin
    if (stall) stall_cnt++;
    check("stall", 32'(stall), 32'(e_stall));
    check("misaligned_fault", 32'(fault), 32'(e_fault));
    check("dmem_req", 32'(req), 32'(e_req));
    check("load_data", load_data, e_load);
    if (e_req) begin
      check("dmem_addr", daddr, e_addr);
      check("dmem_be", 32'(be), 32'(e_be));
      check("dmem_we", 32'(we), 32'(e_we));
      if (e_we) check("dmem_wdata", dwdata, e_wd);
    end
  end

  task automatic access(mem_op_t o, logic [31:0] a, logic [31:0] d, int gw, int rw, logic [31:0] rd);
    bit ld = is_load(o);
    bit mis = m_mis(o, a);
    rd_ctrl = ld; wr_ctrl = !ld; op = o; addr = a; wdata = d;
    e_stall = !mis; e_fault = mis; e_req = 0; stall_cnt = 0;
    if (mis) begin
      @(posedge clk); #1;
      rd_ctrl = 0; wr_ctrl = 0; e_fault = 0; e_stall = 0;
      check("mis_stall_cycles", 32'(stall_cnt), 0);
      return;
    end
    e_addr = a & ~32'h3; e_be = m_be(o, a); e_wd = m_wd(o, d); e_we = !ld;
    @(posedge clk); #1;
    e_req = 1;
    repeat (gw) begin
      gnt = 0; rvalid = 1'($urandom % 2); rdata = $urandom;
      @(posedge clk); #1;
    end
    gnt = 1; rvalid = 0;
    @(posedge clk); #1;
    gnt = 0; e_req = 0;
    if (ld) begin
      repeat (rw) @(posedge clk); #1;
      rvalid = 1; rdata = rd;
      @(posedge clk); #1;
      rvalid = 0; rdata = $urandom;
      e_load = m_ld(o, rd, a);
    end
    e_stall = 0;
    @(posedge clk); #1;
    rd_ctrl = 0; wr_ctrl = 0;
    check("stall_cycles", 32'(stall_cnt), 32'(ld ? gw + rw + 3 : gw + 2));
  endtask

  initial begin
    check("model_lb", m_ld(MEM_LB, 32'h80112233, 32'h103), 32'hFFFFFF80);
    check("model_lbu", m_ld(MEM_LBU, 32'h80112233, 32'h103), 32'h00000080);
    check("model_sh_be", 32'(m_be(MEM_SH, 32'h202)), 32'hC);
    check("model_sh_wd", m_wd(MEM_SH, 32'h1234ABCD), 32'hABCDABCD);
    check("model_sb_be", 32'(m_be(MEM_SB, 32'h7)), 32'h8);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    access(MEM_LW, 32'h100, 0, 0, 0, 32'hDEADBEEF);
    check("lw_literal", load_data, 32'hDEADBEEF);
    access(MEM_LB, 32'h103, 0, 0, 0, 32'h80112233);
    check("lb_literal", load_data, 32'hFFFFFF80);
    access(MEM_LBU, 32'h103, 0, 0, 1, 32'h80112233);
    check("lbu_literal", load_data, 32'h00000080);
    access(MEM_SH, 32'h202, 32'h1234ABCD, 0, 0, 0);
    access(MEM_SB, 32'h7, 32'h55, 3, 0, 0);
    access(MEM_LW, 32'h102, 0, 0, 0, 0);
    access(MEM_SW, 32'h101, 32'h1, 0, 0, 0);
    access(MEM_LHU, 32'h105, 0, 0, 0, 0);
    // reset while waiting in RESP, then a late rvalid must be ignored
    rd_ctrl = 1; op = MEM_LW; addr = 32'h300;
    e_stall = 1; e_addr = 32'h300; e_be = 4'hF; e_we = 0;
    @(posedge clk); #1;
    e_req = 1; gnt = 1;
    @(posedge clk); #1;
    gnt = 0; e_req = 0;
    @(posedge clk); #1;
    rst = 1; rd_ctrl = 0; e_stall = 0; e_load = 0;
    @(posedge clk); #1;
    rst = 0; rvalid = 1; rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    rvalid = 0;
    check("load_after_reset", load_data, 32'h0);
    access(MEM_LH, 32'h402, 0, 1, 2, 32'h8001FFFF);
    check("lh_literal", load_data, 32'hFFFF8001);
    for (int i = 0; i < 300; i++) begin
      mem_op_t o = mem_op_t'(3'($urandom_range(7)));
      access(o, $urandom, $urandom, int'($urandom_range(3)), int'($urandom_range(3)), $urandom);
    end
    repeat (3) @(posedge clk);
    #1 $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
